// File: rtl/ctrl_pkg.sv
// Shared definitions for the controller FSM and its sequencer stage.
package ctrl_pkg;

  // FSM state encoding, shared with the controller FSM.
  typedef enum logic [2:0] {
    S1 = 3'b000,  // ALLOC
    S2 = 3'b001,  // LOAD_AND_INIT
    S3 = 3'b010,  // CONVOLUTION
    S4 = 3'b011,  // LOAD_RESULT
    S5 = 3'b100,  // LOAD_ERROR
    S6 = 3'b101,  // LOAD_OUTPUT
    S7 = 3'b110,  // LOAD_INPUT
    S8 = 3'b111   // PC_INCREMENT
  } ctrl_state_e;

  // Counter width for a modulus of n.
  // A modulus of 1 still needs one bit, so the port is never zero-width.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ctrl_sequencer_counter.sv
// Modulo-N counter with synchronous clear, used for the tap, stage and vector indices.
module mod_counter
  import ctrl_pkg::*;
#(
  parameter int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  // Clear has priority over increment.
  // The counter wraps to zero from N-1, and holds when en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        cnt <= at_max ? '0 : cnt + W'(1);
      end
    end
  end

  assign at_max = (cnt == MAX);

endmodule

// File: rtl/ctrl_sequencer.sv
// Datapath sequencer downstream of the controller FSM.
// Decodes the FSM state into strobes, owns the tap/stage/vector counters,
// and returns the loop flags to the FSM.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int TAPS    = 16,
  parameter int STAGES  = 4,
  parameter int VECTORS = 2,
  localparam int TW = clog2_min1(TAPS),
  localparam int SW = clog2_min1(STAGES),
  localparam int VW = clog2_min1(VECTORS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       state,
  output logic             vector_pass,
  output logic             last_stage,
  output logic             last_vector,
  output logic [TW-1:0]    tap_idx,
  output logic [VW+TW-1:0] coef_addr,
  output logic [SW-1:0]    stage_idx,
  output logic [VW-1:0]    vector_idx,
  output logic             ram_we,
  output logic             mac_init,
  output logic             mac_en,
  output logic             rf_we_res,
  output logic             rf_we_err,
  output logic             out_valid,
  output logic             in_ready,
  output logic             alloc_inc
);

  localparam int AW = VW + TW;

  ctrl_state_e cur_state;
  logic        tap_last;

  assign cur_state = ctrl_state_e'(state);

  mod_counter #(.N(TAPS)) u_tap (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (cur_state == S2),
    .inc    (cur_state == S3),
    .cnt    (tap_idx),
    .at_max (tap_last)
  );

  mod_counter #(.N(STAGES)) u_stage (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (1'b0),
    .inc    (cur_state == S8),
    .cnt    (stage_idx),
    .at_max (last_stage)
  );

  // The vector index advances only when the stage index wraps.
  // Both counters therefore roll over on the same edge.
  mod_counter #(.N(VECTORS)) u_vector (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (1'b0),
    .inc    ((cur_state == S8) && last_stage),
    .cnt    (vector_idx),
    .at_max (last_vector)
  );

  // vector_pass fires in the same cycle as the last tap, so the MAC sees exactly TAPS accumulates.
  assign vector_pass = rst && (cur_state == S3) && tap_last;

  // The coefficient address is sized to hold VECTORS*TAPS-1 without truncation.
  assign coef_addr = AW'(vector_idx) * AW'(TAPS) + AW'(tap_idx);

  // One-hot strobe decode.
  // Every strobe is held low while en is low or reset is asserted.
  always_comb begin
    ram_we    = 1'b0;
    mac_init  = 1'b0;
    mac_en    = 1'b0;
    rf_we_res = 1'b0;
    rf_we_err = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    alloc_inc = 1'b0;
    if (en && rst) begin
      case (cur_state)
        S2: begin
          ram_we   = 1'b1;
          mac_init = 1'b1;
        end
        S3:      mac_en    = 1'b1;
        S4:      rf_we_res = 1'b1;
        S5:      rf_we_err = 1'b1;
        S6:      out_valid = 1'b1;
        S7:      in_ready  = 1'b1;
        S8:      alloc_inc = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer.
// Runs the default build alongside a TAPS=STAGES=VECTORS=1 build.
module tb_ctrl_sequencer;
  import ctrl_pkg::*;

  logic clk;
  logic rst;
  logic en;
  logic [2:0] state;

  // Default build (16 taps, 4 stages, 2 vectors).
  logic       vector_pass, last_stage, last_vector;
  logic [3:0] tap_idx;
  logic [4:0] coef_addr;
  logic [1:0] stage_idx;
  logic [0:0] vector_idx;
  logic ram_we, mac_init, mac_en, rf_we_res, rf_we_err, out_valid, in_ready, alloc_inc;
  logic [7:0] strobes;

  // Minimal build (1 tap, 1 stage, 1 vector).
  logic       m_vector_pass, m_last_stage, m_last_vector;
  logic [0:0] m_tap_idx;
  logic [1:0] m_coef_addr;
  logic [0:0] m_stage_idx;
  logic [0:0] m_vector_idx;
  logic m_ram_we, m_mac_init, m_mac_en, m_rf_we_res, m_rf_we_err, m_out_valid, m_in_ready, m_alloc_inc;

  int checks = 0;
  int errors = 0;

  // Strobes packed as {alloc_inc, in_ready, out_valid, rf_we_err, rf_we_res, mac_en, mac_init, ram_we}.
  logic [7:0] exp_strobe [8] = '{8'h00, 8'h03, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  assign strobes = {alloc_inc, in_ready, out_valid, rf_we_err, rf_we_res, mac_en, mac_init, ram_we};

  ctrl_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .state(state),
    .vector_pass(vector_pass), .last_stage(last_stage), .last_vector(last_vector),
    .tap_idx(tap_idx), .coef_addr(coef_addr), .stage_idx(stage_idx), .vector_idx(vector_idx),
    .ram_we(ram_we), .mac_init(mac_init), .mac_en(mac_en), .rf_we_res(rf_we_res),
    .rf_we_err(rf_we_err), .out_valid(out_valid), .in_ready(in_ready), .alloc_inc(alloc_inc)
  );

  ctrl_sequencer #(.TAPS(1), .STAGES(1), .VECTORS(1)) dut_min (
    .clk(clk), .rst(rst), .en(en), .state(state),
    .vector_pass(m_vector_pass), .last_stage(m_last_stage), .last_vector(m_last_vector),
    .tap_idx(m_tap_idx), .coef_addr(m_coef_addr), .stage_idx(m_stage_idx), .vector_idx(m_vector_idx),
    .ram_we(m_ram_we), .mac_init(m_mac_init), .mac_en(m_mac_en), .rf_we_res(m_rf_we_res),
    .rf_we_err(m_rf_we_err), .out_valid(m_out_valid), .in_ready(m_in_ready), .alloc_inc(m_alloc_inc)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive new inputs on the falling edge, then settle before sampling.
  task automatic apply_stimulus(input logic [2:0] st, input logic e);
    @(negedge clk);
    state = st;
    en    = e;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Linear directed sequence.
  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    state = 3'(S1);
    #2 rst = 1'b0;

    // Reset state, with en high in S2 to prove the strobes are masked.
    apply_stimulus(3'(S2), 1'b1);
    check_output("rst_tap", 32'(tap_idx), 0);
    check_output("rst_stage", 32'(stage_idx), 0);
    check_output("rst_vector", 32'(vector_idx), 0);
    check_output("rst_strobes", 32'(strobes), 0);
    check_output("rst_vpass", 32'(vector_pass), 0);
    check_output("rst_last_stage", 32'(last_stage), 0);
    check_output("rst_last_vector", 32'(last_vector), 0);
    check_output("rst_min_last_stage", 32'(m_last_stage), 1);
    check_output("rst_min_last_vector", 32'(m_last_vector), 1);
    rst = 1'b1;

    // With en low, every strobe stays low and the counters hold.
    for (int s = 0; s < 8; s++) begin
      apply_stimulus(3'(s), 1'b0);
      check_output($sformatf("en0_strobes_s%0d", s + 1), 32'(strobes), 0);
    end
    apply_stimulus(3'(S1), 1'b0);
    check_output("en0_tap_hold", 32'(tap_idx), 0);
    check_output("en0_stage_hold", 32'(stage_idx), 0);

    // One-hot strobe decode across all eight states.
    for (int s = 0; s < 8; s++) begin
      apply_stimulus(3'(s), 1'b1);
      check_output($sformatf("strobes_s%0d", s + 1), 32'(strobes), 32'(exp_strobe[s]));
    end

    // Reset pulse to clear the sweep's side effects.
    apply_stimulus(3'(S1), 1'b0);
    rst = 1'b0;
    #1 rst = 1'b1;

    // Tap sweep: S2, then 16 cycles of S3.
    apply_stimulus(3'(S2), 1'b1);
    check_output("s2_mac_init", 32'(mac_init), 1);
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(3'(S3), 1'b1);
      check_output($sformatf("tap_idx_%0d", i), 32'(tap_idx), 32'(i));
      check_output($sformatf("tap_mac_en_%0d", i), 32'(mac_en), 1);
      check_output($sformatf("tap_vpass_%0d", i), 32'(vector_pass), (i == 15) ? 1 : 0);
      check_output($sformatf("tap_coef_%0d", i), 32'(coef_addr), 32'(i));
      check_output($sformatf("min_vpass_%0d", i), 32'(m_vector_pass), 1);
      check_output($sformatf("min_tap_%0d", i), 32'(m_tap_idx), 0);
    end
    apply_stimulus(3'(S4), 1'b1);
    check_output("tap_wrapped", 32'(tap_idx), 0);
    check_output("vpass_after_s3", 32'(vector_pass), 0);

    // Eight S8 pulses walk stage 0..3 twice and the vector index 0,1,0.
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(3'(S8), 1'b1);
      check_output($sformatf("stage_%0d", k), 32'(stage_idx), 32'(k % 4));
      check_output($sformatf("vector_%0d", k), 32'(vector_idx), 32'(k / 4));
      check_output($sformatf("last_stage_%0d", k), 32'(last_stage), (k % 4 == 3) ? 1 : 0);
      check_output($sformatf("last_vector_%0d", k), 32'(last_vector), (k / 4 == 1) ? 1 : 0);
      check_output($sformatf("coef_vec_%0d", k), 32'(coef_addr), 32'((k / 4) * 16));
      check_output($sformatf("min_flags_%0d", k), 32'({m_last_stage, m_last_vector}), 3);
      check_output($sformatf("min_coef_%0d", k), 32'(m_coef_addr), 0);
    end
    apply_stimulus(3'(S1), 1'b1);
    check_output("stage_wrap", 32'(stage_idx), 0);
    check_output("vector_wrap", 32'(vector_idx), 0);
    check_output("last_vector_wrap", 32'(last_vector), 0);

    // Advance to vector 1, then check the coefficient address mixes both indices.
    for (int k = 0; k < 4; k++) apply_stimulus(3'(S8), 1'b1);
    apply_stimulus(3'(S2), 1'b1);
    check_output("coef_v1_s2", 32'(coef_addr), 16);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(3'(S3), 1'b1);
      check_output($sformatf("coef_v1_t%0d", i), 32'(coef_addr), 32'(16 + i));
    end

    // en toggling in S3: the tap advances only on enabled cycles.
    apply_stimulus(3'(S3), 1'b0);
    check_output("gate_tap_a", 32'(tap_idx), 3);
    check_output("gate_mac_en_a", 32'(mac_en), 0);
    check_output("gate_coef_a", 32'(coef_addr), 19);
    apply_stimulus(3'(S3), 1'b1);
    check_output("gate_tap_b", 32'(tap_idx), 3);
    check_output("gate_mac_en_b", 32'(mac_en), 1);
    apply_stimulus(3'(S3), 1'b0);
    check_output("gate_tap_c", 32'(tap_idx), 4);
    check_output("gate_mac_en_c", 32'(mac_en), 0);
    apply_stimulus(3'(S3), 1'b1);
    check_output("gate_tap_d", 32'(tap_idx), 4);

    // Reach tap 7, stage 2 for the mid-cycle reset.
    apply_stimulus(3'(S8), 1'b1);
    check_output("pre_rst_tap_hold", 32'(tap_idx), 5);
    apply_stimulus(3'(S8), 1'b1);
    apply_stimulus(3'(S3), 1'b1);
    apply_stimulus(3'(S3), 1'b1);
    apply_stimulus(3'(S4), 1'b1);
    check_output("pre_rst_tap", 32'(tap_idx), 7);
    check_output("pre_rst_stage", 32'(stage_idx), 2);
    check_output("pre_rst_vector", 32'(vector_idx), 1);
    check_output("pre_rst_strobes", 32'(strobes), 32'h08);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b0;
    #1;
    check_output("async_tap", 32'(tap_idx), 0);
    check_output("async_stage", 32'(stage_idx), 0);
    check_output("async_vector", 32'(vector_idx), 0);
    check_output("async_strobes", 32'(strobes), 0);
    check_output("async_coef", 32'(coef_addr), 0);
    @(negedge clk);
    state = 3'(S3);
    #1;
    check_output("rst_held_vpass", 32'(vector_pass), 0);
    check_output("rst_held_min_vpass", 32'(m_vector_pass), 0);
    rst = 1'b1;
    #1;
    check_output("min_vpass_first_s3", 32'(m_vector_pass), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
